// File: rtl/jam_pkg.sv
// Shared types and width helpers for the exhaustive job-assignment solver.
// Width helpers are constant functions so they can size ports.
package jam_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } jam_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // N costs of at most 2^cost_w-1 always fit, strictly below all-ones.
    function automatic int sum_width(input int n, input int cost_w);
        return cost_w + clog2(n);
    endfunction

endpackage

// File: rtl/jam_perm_next.sv
// Combinational next-lexicographic-permutation step over N packed indices.
// is_last flags a strictly descending input; perm_out is then don't-care.
module jam_perm_next
    import jam_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N*IDX_W-1:0] perm_in,
    output logic [N*IDX_W-1:0] perm_out,
    output logic               is_last
);

    logic [IDX_W-1:0] p [N];
    logic [IDX_W-1:0] q [N];
    logic [IDX_W-1:0] r [N];
    logic [IDX_W-1:0] piv_val;
    logic [IDX_W-1:0] succ_val;
    int               piv;
    int               succ;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign p[gi] = perm_in[gi*IDX_W +: IDX_W];
            assign perm_out[gi*IDX_W +: IDX_W] = r[gi];
        end
    endgenerate

    always_comb begin
        is_last  = 1'b1;
        piv      = 0;
        piv_val  = '0;
        succ     = N - 1;
        succ_val = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (p[i] < p[i+1]) begin
                is_last = 1'b0;
                piv     = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i == piv) piv_val = p[i];
        end
        // The suffix is descending, so the rightmost greater element is the smallest one.
        for (int i = 0; i < N; i++) begin
            if (i > piv && p[i] > piv_val) succ = i;
        end
        for (int i = 0; i < N; i++) begin
            if (i == succ) succ_val = p[i];
        end
        for (int i = 0; i < N; i++) begin
            if (i == piv)       q[i] = succ_val;
            else if (i == succ) q[i] = piv_val;
            else                q[i] = p[i];
        end
        for (int i = 0; i < N; i++) begin
            r[i] = q[i];
            if (i > piv) begin
                for (int s = 0; s < N; s++) begin
                    if (s == N + piv - i) r[i] = q[s];
                end
            end
        end
    end

endmodule

// File: rtl/jam_search.sv
// Exhaustive N x N assignment search: walks all permutations in lexicographic
// order, summing external costs, and keeps min total, match count and first best.
module jam_search
    import jam_pkg::*;
#(
    parameter  int N      = 8,
    parameter  int COST_W = 7,
    parameter  int MC_W   = 16,
    localparam int IDX_W  = idx_width(N),
    localparam int SUM_W  = sum_width(N, COST_W)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 Start,
    output logic [IDX_W-1:0]     W,
    output logic [IDX_W-1:0]     J,
    input  logic [COST_W-1:0]    Cost,
    output logic [MC_W-1:0]      MatchCount,
    output logic [SUM_W-1:0]     MinCost,
    output logic [N*IDX_W-1:0]   BestPerm,
    output logic                 Busy,
    output logic                 Valid
);

    function automatic logic [N*IDX_W-1:0] identity_perm();
        logic [N*IDX_W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*IDX_W +: IDX_W] = IDX_W'(i);
        return v;
    endfunction

    localparam logic [N*IDX_W-1:0] IDENT  = identity_perm();
    localparam logic [IDX_W-1:0]   K_LAST = IDX_W'(N - 1);

    jam_state_t         state_reg, state_next;
    logic [IDX_W-1:0]   k_reg, k_next;
    logic [IDX_W-1:0]   w_reg, w_next;
    logic [IDX_W-1:0]   j_reg, j_next;
    logic [N*IDX_W-1:0] perm_reg, perm_next;
    logic [N*IDX_W-1:0] best_reg, best_next;
    logic [SUM_W-1:0]   sum_reg, sum_next;
    logic [SUM_W-1:0]   min_reg, min_next;
    logic [MC_W-1:0]    cnt_reg, cnt_next;
    logic [N*IDX_W-1:0] perm_succ;
    logic               perm_last;
    logic [IDX_W-1:0]   perm_arr [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_perm_arr
            assign perm_arr[gi] = perm_reg[gi*IDX_W +: IDX_W];
        end
    endgenerate

    jam_perm_next #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_perm_next (
        .perm_in  (perm_reg),
        .perm_out (perm_succ),
        .is_last  (perm_last)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            w_reg     <= '0;
            j_reg     <= '0;
            perm_reg  <= IDENT;
            best_reg  <= '0;
            sum_reg   <= '0;
            min_reg   <= '1;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            w_reg     <= w_next;
            j_reg     <= j_next;
            perm_reg  <= perm_next;
            best_reg  <= best_next;
            sum_reg   <= sum_next;
            min_reg   <= min_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        w_next     = w_reg;
        j_next     = j_reg;
        perm_next  = perm_reg;
        best_next  = best_reg;
        sum_next   = sum_reg;
        min_next   = min_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    state_next = SCAN;
                    perm_next  = IDENT;
                    sum_next   = '0;
                    min_next   = '1;
                    cnt_next   = '0;
                    k_next     = '0;
                    w_next     = '0;
                    j_next     = '0;
                end
            end
            SCAN: begin
                sum_next = sum_reg + SUM_W'(Cost);
                if (k_reg == K_LAST) begin
                    state_next = UPDATE;
                    w_next     = '0;
                    j_next     = '0;
                end else begin
                    // W/J are registered, so present the next worker's job one cycle ahead.
                    k_next = k_reg + IDX_W'(1);
                    w_next = k_reg + IDX_W'(1);
                    j_next = '0;
                    for (int i = 0; i < N; i++) begin
                        if (i == int'(k_reg) + 1) j_next = perm_arr[i];
                    end
                end
            end
            UPDATE: begin
                if (sum_reg < min_reg) begin
                    min_next  = sum_reg;
                    cnt_next  = MC_W'(1);
                    best_next = perm_reg;
                end else if (sum_reg == min_reg && cnt_reg != '1) begin
                    cnt_next = cnt_reg + MC_W'(1);
                end
                sum_next = '0;
                if (perm_last) begin
                    state_next = DONE;
                end else begin
                    state_next = SCAN;
                    perm_next  = perm_succ;
                    k_next     = '0;
                    w_next     = '0;
                    j_next     = perm_succ[IDX_W-1:0];
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign W          = w_reg;
    assign J          = j_reg;
    assign MatchCount = cnt_reg;
    assign MinCost    = min_reg;
    assign BestPerm   = best_reg;
    assign Busy       = (state_reg == SCAN) || (state_reg == UPDATE);
    assign Valid      = (state_reg == DONE);

endmodule

// File: tb/tb_jam_search.sv
// Directed bench for jam_search: N=3 and N=4 instances (one with a 4-bit
// saturating count) against hand-computed and brute-force expected results.
module tb_jam_search;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST_N;
    logic        start3, start4;
    logic [1:0]  w3, j3, w4, j4, w4s, j4s;
    logic [6:0]  cost3, cost4, cost4s;
    logic [15:0] mc3, mc4;
    logic [3:0]  mc4s;
    logic [8:0]  min3, min4, min4s;
    logic [5:0]  best3;
    logic [7:0]  best4, best4s;
    logic        busy3, valid3, busy4, valid4, busy4s, valid4s;

    logic [6:0]  tbl3 [4][4];
    logic [6:0]  tbl4 [4][4];

    assign cost3  = tbl3[w3][j3];
    assign cost4  = tbl4[w4][j4];
    assign cost4s = tbl4[w4s][j4s];

    int total;
    int bad;
    int cyc;
    int gp [4];
    int exp_min, exp_cnt, exp_best;

    jam_search #(.N(3), .COST_W(7), .MC_W(16)) u3 (
        .CLK(CLK), .RST_N(RST_N), .Start(start3), .W(w3), .J(j3), .Cost(cost3),
        .MatchCount(mc3), .MinCost(min3), .BestPerm(best3), .Busy(busy3), .Valid(valid3)
    );

    jam_search #(.N(4), .COST_W(7), .MC_W(16)) u4 (
        .CLK(CLK), .RST_N(RST_N), .Start(start4), .W(w4), .J(j4), .Cost(cost4),
        .MatchCount(mc4), .MinCost(min4), .BestPerm(best4), .Busy(busy4), .Valid(valid4)
    );

    jam_search #(.N(4), .COST_W(7), .MC_W(4)) u4s (
        .CLK(CLK), .RST_N(RST_N), .Start(start4), .W(w4s), .J(j4s), .Cost(cost4s),
        .MatchCount(mc4s), .MinCost(min4s), .BestPerm(best4s), .Busy(busy4s), .Valid(valid4s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference lexicographic successor on gp[0..3].
    function automatic void step_perm();
        int i, j, t, a, b;
        i = 2;
        while (i >= 0 && gp[i] >= gp[i+1]) i--;
        if (i < 0) return;
        j = 3;
        while (gp[j] <= gp[i]) j--;
        t = gp[i]; gp[i] = gp[j]; gp[j] = t;
        a = i + 1;
        b = 3;
        while (a < b) begin
            t = gp[a]; gp[a] = gp[b]; gp[b] = t;
            a++;
            b--;
        end
    endfunction

    function automatic void brute4();
        int s;
        for (int i = 0; i < 4; i++) gp[i] = i;
        exp_min = 1 << 30;
        exp_cnt = 0;
        exp_best = 0;
        for (int n = 0; n < 24; n++) begin
            s = 0;
            for (int w = 0; w < 4; w++) s += int'(tbl4[w][gp[w]]);
            if (s < exp_min) begin
                exp_min  = s;
                exp_cnt  = 1;
                exp_best = gp[0] | (gp[1] << 2) | (gp[2] << 4) | (gp[3] << 6);
            end else if (s == exp_min) begin
                exp_cnt++;
            end
            step_perm();
        end
    endfunction

    task automatic run3(input int pulse_at, output int n);
        @(negedge CLK);
        start3 = 1'b1;
        @(posedge CLK);
        #1;
        start3 = 1'b0;
        n = 1;
        check("n3_busy_first", busy3, 1);
        while (!valid3 && n < 200) begin
            start3 = (n == pulse_at);
            @(posedge CLK);
            #1;
            n++;
        end
        start3 = 1'b0;
        check("n3_busy_at_valid", busy3, 0);
        @(posedge CLK);
        #1;
        check("n3_valid_one_pulse", valid3, 0);
    endtask

    task automatic run4(input bit chk_seq, output int n);
        int p;
        for (int i = 0; i < 4; i++) gp[i] = i;
        @(negedge CLK);
        start4 = 1'b1;
        @(posedge CLK);
        #1;
        start4 = 1'b0;
        n = 1;
        while (!valid4 && n < 400) begin
            if (chk_seq) begin
                p = (n - 1) % 5;
                if (p < 4) begin
                    check("n4_w_seq", w4, p);
                    check("n4_j_seq", j4, gp[p]);
                end else begin
                    step_perm();
                end
            end
            @(posedge CLK);
            #1;
            n++;
        end
        check("n4s_valid_aligned", valid4s, 1);
        check("n4_busy_at_valid", busy4, 0);
        @(posedge CLK);
        #1;
        check("n4_valid_one_pulse", valid4, 0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        start3 = 1'b0;
        start4 = 1'b0;
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < 4; j++) begin
                tbl3[w][j] = '0;
                tbl4[w][j] = '0;
            end

        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_w", w3, 0);
        check("rst_j", j3, 0);
        check("rst_mc", mc3, 0);
        check("rst_min", min3, 9'h1FF);
        check("rst_best", best3, 0);
        check("rst_busy", busy3, 0);
        check("rst_valid", valid3, 0);
        check("rst_min4", min4, 9'h1FF);
        @(negedge CLK);
        RST_N = 1'b1;

        // Ramp matrix: every permutation totals 12.
        for (int w = 0; w < 3; w++)
            for (int j = 0; j < 3; j++) tbl3[w][j] = 7'(3 * w + j);
        run3(0, cyc);
        check("ramp_latency", cyc, 25);
        check("ramp_min", min3, 12);
        check("ramp_count", mc3, 6);
        check("ramp_best", best3, 6'h24);
        repeat (3) @(posedge CLK);
        #1;
        check("idle_hold_min", min3, 12);
        check("idle_hold_count", mc3, 6);
        check("idle_busy", busy3, 0);

        // Diagonal 9, others 1; a second Start mid-search must be ignored.
        for (int w = 0; w < 3; w++)
            for (int j = 0; j < 3; j++) tbl3[w][j] = (w == j) ? 7'd9 : 7'd1;
        run3(10, cyc);
        check("diag_latency", cyc, 25);
        check("diag_min", min3, 3);
        check("diag_count", mc3, 2);
        check("diag_best", best3, 6'h09);

        // All-zero N=4: every permutation ties, 4-bit count saturates.
        run4(1'b1, cyc);
        check("zero4_latency", cyc, 121);
        check("zero4_min", min4, 0);
        check("zero4_count", mc4, 24);
        check("zero4_best", best4, 8'hE4);
        check("zero4s_min", min4s, 0);
        check("zero4s_count_sat", mc4s, 15);
        check("zero4s_best", best4s, 8'hE4);

        // Random N=4 matrix against the brute-force reference.
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < 4; j++) tbl4[w][j] = 7'($urandom_range(0, 127));
        brute4();
        run4(1'b0, cyc);
        check("rand4_latency", cyc, 121);
        check("rand4_min", min4, exp_min);
        check("rand4_count", mc4, exp_cnt);
        check("rand4_best", best4, exp_best);
        check("rand4s_min", min4s, exp_min);
        check("rand4s_count", mc4s, (exp_cnt > 15) ? 15 : exp_cnt);
        check("rand4s_best", best4s, exp_best);

        // Asynchronous reset in the middle of a ramp search.
        for (int w = 0; w < 3; w++)
            for (int j = 0; j < 3; j++) tbl3[w][j] = 7'(3 * w + j);
        @(negedge CLK);
        start3 = 1'b1;
        @(posedge CLK);
        #1;
        start3 = 1'b0;
        repeat (7) @(posedge CLK);
        #2;
        check("midrst_busy_before", busy3, 1);
        RST_N = 1'b0;
        #1;
        check("midrst_busy", busy3, 0);
        check("midrst_valid", valid3, 0);
        check("midrst_min", min3, 9'h1FF);
        check("midrst_count", mc3, 0);
        check("midrst_best", best3, 0);
        check("midrst_w", w3, 0);
        check("midrst_j", j3, 0);
        repeat (3) @(posedge CLK);
        #1;
        check("midrst_no_valid", valid3, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        run3(0, cyc);
        check("after_rst_latency", cyc, 25);
        check("after_rst_min", min3, 12);
        check("after_rst_count", mc3, 6);
        check("after_rst_best", best3, 6'h24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jam_search.md
# jam_search

Parametrised exhaustive job-assignment solver. It enumerates every permutation of N jobs over N workers in lexicographic order and reads each worker/job cost from an external cost table through the W/J/Cost port. It reports the minimum total cost, the number of permutations achieving it, and the first optimal permutation found. The block is the successor of the fixed 8×8 solver: N, cost width and count width are parameters, and it adds a Start/Busy handshake, a saturating count and a best-assignment output.

## Interface
- N, 8: workers = jobs. Legal range 2..8.
- COST_W, 7: width of one cost entry.
- MC_W, 16: MatchCount width. The count saturates at all-ones.
- Derived localparams: IDX_W = max(1, clog2(N)); SUM_W = COST_W + clog2(N).

Ports:
- CLK  in  1: clock. One clock domain only.
- RST_N  in  1: asynchronous, active-low reset.
- Start  in  1: one-cycle request to begin a search. Sampled only in IDLE.
- W  out  IDX_W: worker index presented to the cost table.
- J  out  IDX_W: job index presented to the cost table.
- Cost  in  COST_W: cost of (W,J). Combinational from the registered W/J; sampled in the same cycle.
- MatchCount  out  MC_W: number of permutations with total == MinCost.
- MinCost  out  SUM_W: minimum total cost.
- BestPerm  out  N*IDX_W: job for worker k in bits [k*IDX_W +: IDX_W]. Holds the first optimal permutation found.
- Busy  out  1: high from the cycle after Start is accepted until Valid.
- Valid  out  1: one-cycle pulse; results are final.

## Operation
- Internal permutation register perm[0..N-1] and running sum (SUM_W).
- States:
  - IDLE: W=0, J=0. If Start=1, load perm = identity, sum=0, MinCost = all-ones, MatchCount=0, k=0, then go to SCAN.
  - SCAN: lasts N cycles, k = 0..N-1. Drive W=k, J=perm[k]; sum += Cost at each edge. After k=N-1 go to UPDATE.
  - UPDATE: one cycle, compare sum against MinCost.
    - sum < MinCost: MinCost=sum, MatchCount=1, BestPerm=perm.
    - sum == MinCost: MatchCount += 1, saturating at 2^MC_W−1. BestPerm is unchanged.
    - In the same cycle, clear sum.
    - If perm is strictly descending (last permutation), go to DONE.
    - Otherwise perm = next lexicographic permutation: pivot = largest i with perm[i] < perm[i+1]; swap perm[i] with the smallest greater element to its right; reverse the suffix. All of this completes in one cycle. Then k=0 and go to SCAN.
  - DONE: Valid=1, Busy=0, then go to IDLE.
- Outputs hold their values in IDLE until the next accepted Start.
- Start outside IDLE is ignored.
- Adding N costs of at most 2^COST_W−1 cannot overflow SUM_W.

## Timing
- Reset values:
  - W=0, J=0.
  - MatchCount=0, MinCost=all-ones, BestPerm=0.
  - Busy=0, Valid=0.
  - State IDLE, perm=identity.
- Reset asserted mid-search aborts immediately to these values. No Valid is produced.
- Per permutation: N+1 cycles (N SCAN + 1 UPDATE).
- Start sampled at edge t0: Busy=1 from t0+1. Valid=1 during cycle t0 + N!·(N+1) + 1.
  - N=8: 362 881 cycles.
  - N=3: 25 cycles.
- Cost must be stable before the edge that ends each SCAN cycle. The cost table is a zero-latency read.
- Valid and Busy are never high together.
- MinCost/MatchCount/BestPerm change only in UPDATE cycles.

## Structure
- Package jam_pkg:
  - state enum {IDLE, SCAN, UPDATE, DONE};
  - clog2 helper function;
  - IDX_W/SUM_W derivation functions.
- Sub-module jam_perm_next (combinational, parameter N): inputs perm_in; outputs perm_out and is_last.
- Top module contains the FSM, the SCAN counter, the accumulator and the best-result registers.

## Test plan
- N=3, cost[w][j]=w·3+j (identical totals): MinCost=12, MatchCount=6, BestPerm=identity {0,1,2}. Valid 25 cycles after Start.
- N=3, cost = identity-penalising matrix (diagonal 9, others 1):
  - MinCost=3, MatchCount=2;
  - BestPerm = job for workers 0,1,2 = {1,2,0}.
- N=4, all costs 0: MinCost=0, MatchCount=24. Verify the per-cycle W sequence 0..3 and that J matches the golden permutation order.
- N=8, MC_W=4, all costs 0: MatchCount saturates at 15, MinCost=0. Valid pulses exactly once, at cycle 362 881.
- N=8, random 7-bit matrix: MinCost, MatchCount and BestPerm equal the software brute-force model.
- Start pulsed again mid-search: no restart and no effect.
- RST_N pulled low mid-search: outputs return to reset values asynchronously. A new Start then yields correct results.
